// File: rtl/tilelink_ul_pkg.sv
// Shared TileLink-UL definitions: default widths, A/D opcodes and slave FSM states.
// Imported by both the master and the slave side of the link.
package tilelink_ul_pkg;

  localparam int TL_ADDR_WIDTH_DEF   = 64;
  localparam int TL_DATA_WIDTH_DEF   = 64;
  localparam int TL_SOURCE_WIDTH_DEF = 3;
  localparam int TL_SINK_WIDTH_DEF   = 3;
  localparam int TL_OPCODE_WIDTH_DEF = 3;
  localparam int TL_PARAM_WIDTH_DEF  = 3;
  localparam int TL_SIZE_WIDTH_DEF   = 8;

  localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
  localparam logic [2:0] GET_A              = 3'd4;
  localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/tl_ul_sram.sv
// Single-port synchronous word memory with byte-lane write mask and registered read.
// Read data only changes on a read, so it holds while a response is stalled.
module tl_ul_sram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W/8-1:0]      mask,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (mask[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/tilelink_ul_slave.sv
// TileLink-UL memory slave: one A beat in, one D response out one cycle later.
// Supports Get/PutFullData/PutPartialData over a word-addressed SRAM window at BASE_ADDR.
module tilelink_ul_slave
  import tilelink_ul_pkg::*;
#(
  parameter int          TL_ADDR_WIDTH   = TL_ADDR_WIDTH_DEF,
  parameter int          TL_DATA_WIDTH   = TL_DATA_WIDTH_DEF,
  parameter int          TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int          TL_SOURCE_WIDTH = TL_SOURCE_WIDTH_DEF,
  parameter int          TL_SINK_WIDTH   = TL_SINK_WIDTH_DEF,
  parameter int          TL_OPCODE_WIDTH = TL_OPCODE_WIDTH_DEF,
  parameter int          TL_PARAM_WIDTH  = TL_PARAM_WIDTH_DEF,
  parameter int          TL_SIZE_WIDTH   = TL_SIZE_WIDTH_DEF,
  parameter logic [63:0] BASE_ADDR       = 64'h1000_0000,
  parameter int          MEM_DEPTH       = 256,
  parameter int          SINK_ID         = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  d_param,
  output logic [TL_SIZE_WIDTH-1:0]   d_size,
  output logic [TL_SINK_WIDTH-1:0]   d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] d_source,
  output logic [TL_DATA_WIDTH-1:0]   d_data,
  output logic                       d_error
);

  localparam int OFF_W = $clog2(TL_STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int EXT_W = TL_ADDR_WIDTH + 1;
  // One extra bit so BASE + window size cannot wrap at the top of the address space.
  localparam logic [EXT_W-1:0] BASE_EXT = EXT_W'(BASE_ADDR);
  localparam logic [EXT_W-1:0] END_EXT  = BASE_EXT + EXT_W'(MEM_DEPTH * TL_STRB_WIDTH);

  state_e state, state_next;

  logic                       accept;
  logic                       is_get, is_put, op_err;
  logic                       range_err, size_err, align_err, req_err;
  logic [TL_ADDR_WIDTH-1:0]   offset_addr;
  logic [IDX_W-1:0]           word_idx;
  logic                       mem_we, mem_re;
  logic [TL_DATA_WIDTH-1:0]   rdata;
  logic                       unused;

  logic [TL_OPCODE_WIDTH-1:0] opcode_p1;
  logic [TL_SIZE_WIDTH-1:0]   size_p1;
  logic [TL_SOURCE_WIDTH-1:0] source_p1;
  logic                       error_p1;
  logic                       has_data_p1;

  assign is_get    = (a_opcode == TL_OPCODE_WIDTH'(GET_A));
  assign is_put    = (a_opcode == TL_OPCODE_WIDTH'(PUT_FULL_DATA_A)) ||
                     (a_opcode == TL_OPCODE_WIDTH'(PUT_PARTIAL_DATA_A));
  assign op_err    = !(is_get || is_put);
  assign range_err = ({1'b0, a_address} < BASE_EXT) || ({1'b0, a_address} >= END_EXT);
  assign size_err  = a_size > TL_SIZE_WIDTH'(OFF_W);

  always_comb begin
    align_err = 1'b0;
    for (int i = 0; i < OFF_W; i++) begin
      if ((TL_SIZE_WIDTH'(i) < a_size) && a_address[i]) align_err = 1'b1;
    end
  end

  assign req_err     = op_err || range_err || size_err || align_err;
  assign offset_addr = a_address - BASE_EXT[TL_ADDR_WIDTH-1:0];
  assign word_idx    = offset_addr[OFF_W +: IDX_W];

  assign accept = a_valid && a_ready;
  assign mem_we = accept && is_put && !req_err;
  assign mem_re = accept && is_get && !req_err;
  assign unused = ^{a_param, offset_addr};

  tl_ul_sram #(
    .DATA_W (TL_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_sram (
    .clk   (clk),
    .en    (mem_we || mem_re),
    .we    (mem_we),
    .idx   (word_idx),
    .mask  (a_mask),
    .wdata (a_data),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (d_ready) state_next = accept ? RESP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_ready = (state == IDLE) || d_ready;
    d_valid = (state == RESP);
  end

  // Response stage: captured on accept, frozen otherwise so D holds under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_p1   <= '0;
      size_p1     <= '0;
      source_p1   <= '0;
      error_p1    <= 1'b0;
      has_data_p1 <= 1'b0;
    end else if (accept) begin
      opcode_p1   <= is_get ? TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D) : TL_OPCODE_WIDTH'(ACCESS_ACK_D);
      size_p1     <= a_size;
      source_p1   <= a_source;
      error_p1    <= req_err;
      has_data_p1 <= is_get && !req_err;
    end
  end

  assign d_opcode = opcode_p1;
  assign d_param  = '0;
  assign d_size   = size_p1;
  assign d_sink   = TL_SINK_WIDTH'(SINK_ID);
  assign d_source = source_p1;
  assign d_error  = error_p1;
  assign d_data   = has_data_p1 ? rdata : '0;

endmodule

// File: doc/tilelink_ul_slave.md
TILELINK_UL_SLAVE -- requirements
Module: tilelink_ul_slave

Interface
REQ-001 SHALL have parameters: TL_ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter TL_DATA_WIDTH, default 64, beat width; TL_STRB_WIDTH = TL_DATA_WIDTH/8.
REQ-003 SHALL have parameters TL_SOURCE_WIDTH, TL_SINK_WIDTH, TL_OPCODE_WIDTH and TL_PARAM_WIDTH, all default 3; TL_SIZE_WIDTH, default 8.
REQ-004 SHALL have parameters: BASE_ADDR, default 64'h1000_0000, first byte served; MEM_DEPTH, default 256, words (power of 2); SINK_ID, default 0, value driven on d_sink.
REQ-005 SHALL have ports:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  synchronous, active-high reset.
  - a_valid, a_ready  in/out  1/1  A-channel handshake.
  - a_opcode  in  TL_OPCODE_WIDTH.
  - a_param  in  TL_PARAM_WIDTH  (ignored).
  - a_address  in  TL_ADDR_WIDTH.
  - a_size  in  TL_SIZE_WIDTH  (log2 bytes).
  - a_mask  in  TL_STRB_WIDTH.
  - a_data  in  TL_DATA_WIDTH.
  - a_source  in  TL_SOURCE_WIDTH.
  - d_valid, d_ready  out/in  1/1  D-channel handshake.
  - d_opcode  out  TL_OPCODE_WIDTH.
  - d_param  out  TL_PARAM_WIDTH.
  - d_size  out  TL_SIZE_WIDTH.
  - d_sink  out  TL_SINK_WIDTH.
  - d_source  out  TL_SOURCE_WIDTH.
  - d_data  out  TL_DATA_WIDTH.
  - d_error  out  1.

Function
REQ-006 SHALL implement FSM with states IDLE (no response pending) and RESP (response held on D).
REQ-007 SHALL drive a_ready = (state==IDLE) || d_ready; an A beat is accepted when a_valid && a_ready.
REQ-008 SHALL, on an accepted beat, enter RESP and present d_valid=1 on the next cycle (latency 1).
REQ-009 SHALL hold every D output stable while d_valid && !d_ready.
REQ-010 SHALL, in RESP with d_ready=1 and no A accept, return to IDLE with d_valid=0 next cycle.
REQ-011 SHALL, in RESP with d_ready=1 and a simultaneous A accept, stay in RESP and present the new response next cycle (back-to-back, one beat per cycle).
REQ-012 SHALL decode opcodes: Get (4) -> AccessAckData (1); PutFullData (0), PutPartialData (1) -> AccessAck (0); any other opcode -> AccessAck with d_error=1.
REQ-013 SHALL flag an error when any of these holds:
  - a_address < BASE_ADDR.
  - a_address >= BASE_ADDR + MEM_DEPTH*TL_STRB_WIDTH.
  - a_size > log2(TL_STRB_WIDTH).
  - a_address not aligned to 2^a_size.
REQ-014 SHALL compute word index = (a_address - BASE_ADDR) >> log2(TL_STRB_WIDTH), truncated to log2(MEM_DEPTH) bits.
REQ-015 SHALL, for an error-free Put, write each byte lane i where a_mask[i]=1 in the accept cycle; lanes with mask 0 are unchanged; no write on error.
REQ-016 SHALL, for an error-free Get, return the full addressed word on d_data; on error return d_data=0, d_error=1.
REQ-017 SHALL give a Get accepted in the cycle after a Put to the same word the post-write data.
REQ-018 SHALL echo a_size on d_size and a_source on d_source, and drive d_param=0 and d_sink=SINK_ID.
REQ-019 SHALL drive d_data=0 for AccessAck responses.

Reset
REQ-020 SHALL, while rst=1 at a clock edge, enter IDLE and drive d_valid, d_opcode, d_param, d_size, d_source, d_data and d_error to 0, d_sink=SINK_ID, a_ready=1 after the edge.
REQ-021 SHALL, on reset asserted mid-transaction, discard the pending response; a write already committed stays committed; memory contents are not cleared.

Structure
REQ-022 SHALL take opcode constants (GET_A, PUT_FULL_DATA_A, PUT_PARTIAL_DATA_A, ACCESS_ACK_D, ACCESS_ACK_DATA_D) and default widths from shared package tilelink_ul_pkg, shared with the master.
REQ-023 SHALL place storage in sub-module tl_ul_sram: single port, synchronous, byte-masked write, registered read.

Verification
REQ-024 Scenario: Put 0 to 0x1000_0000, data DEAD_BEEF_CAFE_BABE, mask FF, size 3, source 1 -> next cycle: d_valid=1, opcode 0, source 1, size 3, error 0.
REQ-025 Scenario: Get 4 to 0x1000_0000, source 2, after REQ-024 -> next cycle: opcode 1, d_data=DEAD_BEEF_CAFE_BABE, source 2.
REQ-026 Scenario: PutPartialData mask 0x0F, data 0x1111_1111_2222_2222, same address, then Get -> d_data=DEAD_BEEF_2222_2222.
REQ-027 Scenario: Get to 0x0FFF_FFF8 and to 0x1000_0804 with size 3 -> both d_error=1, d_data=0, no memory change.
REQ-028 Scenario: d_ready=0 for 3 cycles during RESP -> D outputs stable and a_ready=0; a_valid held on a second request is accepted in the cycle d_ready rises, with its response the following cycle.
REQ-029 Scenario: rst pulsed while d_valid=1 -> d_valid=0 and a_ready=1 next cycle; a subsequent Get returns the data written before reset.
